// File: rtl/alarm_controller.sv
// alarm_controller: mode sequencer, alarm time register and ring/snooze
// control for the alarm clock. It sits between the debounced buttons and
// the BCD timekeeping chain.
module alarm_controller #(
    parameter int unsigned RING_SECS   = 60,
    parameter int unsigned SNOOZE_SECS = 300,
    parameter int unsigned SET_TIMEOUT = 30,
    parameter int unsigned ALARM_RST_H = 7
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       tick,
    input  logic [1:0] cur_hh,
    input  logic [3:0] cur_hl,
    input  logic [3:0] cur_mh,
    input  logic [3:0] cur_ml,
    input  logic       btn_mode,
    input  logic       btn_hour,
    input  logic       btn_min,
    input  logic       btn_snooze,
    output logic       inc_hour,
    output logic       inc_min,
    output logic [1:0] al_hh,
    output logic [3:0] al_hl,
    output logic [3:0] al_mh,
    output logic [3:0] al_ml,
    output logic       disp_alarm,
    output logic       blink,
    output logic       armed,
    output logic       buzzer
);

    localparam int unsigned IW = $clog2(SET_TIMEOUT + 1);
    localparam int unsigned RW = $clog2(RING_SECS + 1);
    localparam int unsigned SW = $clog2(SNOOZE_SECS + 1);

    localparam logic [IW-1:0] IDLE_LAST = IW'(SET_TIMEOUT - 1);
    localparam logic [RW-1:0] RING_LAST = RW'(RING_SECS - 1);
    localparam logic [SW-1:0] SNZ_LAST  = SW'(SNOOZE_SECS - 1);
    localparam logic [1:0]    RST_HH    = 2'(ALARM_RST_H / 10);
    localparam logic [3:0]    RST_HL    = 4'(ALARM_RST_H % 10);

    typedef enum logic [2:0] {
        ST_RUN,
        ST_SET_TIME,
        ST_SET_ALARM,
        ST_RINGING,
        ST_SNOOZE
    } state_e;

    state_e        state_q, state_d;
    logic [3:0]    btn_q, btn_d;
    logic [3:0]    btn_prev_q, btn_prev_d;
    logic [IW-1:0] idle_q, idle_d;
    logic [RW-1:0] ring_q, ring_d;
    logic [SW-1:0] snz_q, snz_d;
    logic [1:0]    al_hh_q, al_hh_d;
    logic [3:0]    al_hl_q, al_hl_d;
    logic [3:0]    al_mh_q, al_mh_d;
    logic [3:0]    al_ml_q, al_ml_d;
    logic          armed_q, armed_d;
    logic          match_d_q, match_d_d;
    logic          inc_hour_q, inc_hour_d;
    logic          inc_min_q, inc_min_d;
    logic          buzzer_q, buzzer_d;
    logic          blink_q, blink_d;
    logic          disp_alarm_q, disp_alarm_d;

    logic [3:0] press;
    logic       p_mode, p_hour, p_min, p_snooze, p_any;
    logic       match;
    logic       entering, set_next;

    // Button sampling and edge detection; mode press masks all others.
    always_comb begin
        btn_d      = {btn_snooze, btn_min, btn_hour, btn_mode};
        btn_prev_d = btn_q;
        press      = btn_prev_q & ~btn_q;
        p_mode     = press[0];
        p_hour     = press[1] & ~press[0];
        p_min      = press[2] & ~press[0];
        p_snooze   = press[3] & ~press[0];
        p_any      = |press;
        match      = ({cur_hh, cur_hl, cur_mh, cur_ml} == {al_hh_q, al_hl_q, al_mh_q, al_ml_q});
        match_d_d  = match;
    end

    // Next-state, counters, alarm register and registered output values.
    always_comb begin
        state_d    = state_q;
        idle_d     = idle_q;
        ring_d     = ring_q;
        snz_d      = snz_q;
        al_hh_d    = al_hh_q;
        al_hl_d    = al_hl_q;
        al_mh_d    = al_mh_q;
        al_ml_d    = al_ml_q;
        armed_d    = armed_q;
        inc_hour_d = 1'b0;
        inc_min_d  = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (p_mode) begin
                    state_d = ST_SET_TIME;
                end else begin
                    if (p_snooze) armed_d = ~armed_q;
                    if (armed_q && match && !match_d_q) state_d = ST_RINGING;
                end
            end
            ST_SET_TIME: begin
                if (p_mode) begin
                    state_d = ST_SET_ALARM;
                end else if (p_any) begin
                    idle_d     = '0;
                    inc_hour_d = p_hour;
                    inc_min_d  = p_min;
                end else if (tick) begin
                    if (idle_q == IDLE_LAST) state_d = ST_RUN;
                    else idle_d = idle_q + 1'b1;
                end
            end
            ST_SET_ALARM: begin
                if (p_mode) begin
                    state_d = ST_RUN;
                end else if (p_any) begin
                    idle_d = '0;
                    if (p_hour) begin
                        if (al_hh_q == 2'd2 && al_hl_q == 4'd3) begin
                            al_hh_d = '0;
                            al_hl_d = '0;
                        end else if (al_hl_q == 4'd9) begin
                            al_hl_d = '0;
                            al_hh_d = al_hh_q + 2'd1;
                        end else begin
                            al_hl_d = al_hl_q + 4'd1;
                        end
                    end
                    if (p_min) begin
                        if (al_ml_q == 4'd9) begin
                            al_ml_d = '0;
                            al_mh_d = (al_mh_q == 4'd5) ? 4'd0 : al_mh_q + 4'd1;
                        end else begin
                            al_ml_d = al_ml_q + 4'd1;
                        end
                    end
                end else if (tick) begin
                    if (idle_q == IDLE_LAST) state_d = ST_RUN;
                    else idle_d = idle_q + 1'b1;
                end
            end
            ST_RINGING: begin
                if (p_mode) begin
                    state_d = ST_RUN;
                end else if (p_snooze) begin
                    state_d = ST_SNOOZE;
                end else if (tick) begin
                    if (ring_q == RING_LAST) state_d = ST_RUN;
                    else ring_d = ring_q + 1'b1;
                end
            end
            ST_SNOOZE: begin
                if (p_mode) begin
                    state_d = ST_RUN;
                end else if (tick) begin
                    if (snz_q == SNZ_LAST) state_d = ST_RINGING;
                    else snz_d = snz_q + 1'b1;
                end
            end
            default: state_d = ST_RUN;
        endcase

        // Every state change reloads all counters, so a press that coincides
        // with a terminal count leaves the new state with a fresh count.
        entering = (state_d != state_q);
        if (entering) begin
            idle_d = '0;
            ring_d = '0;
            snz_d  = '0;
        end

        set_next = (state_d == ST_SET_TIME) || (state_d == ST_SET_ALARM);
        if (!set_next || entering) blink_d = 1'b1;
        else if (tick)             blink_d = ~blink_q;
        else                       blink_d = blink_q;

        if (state_d != ST_RINGING) buzzer_d = 1'b0;
        else if (entering)         buzzer_d = 1'b1;
        else if (tick)             buzzer_d = ~buzzer_q;
        else                       buzzer_d = buzzer_q;

        disp_alarm_d = (state_d == ST_SET_ALARM);
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk_in) begin
        if (!reset) begin
            state_q      <= ST_RUN;
            btn_q        <= '1;
            btn_prev_q   <= '1;
            idle_q       <= '0;
            ring_q       <= '0;
            snz_q        <= '0;
            al_hh_q      <= RST_HH;
            al_hl_q      <= RST_HL;
            al_mh_q      <= '0;
            al_ml_q      <= '0;
            armed_q      <= 1'b0;
            match_d_q    <= 1'b0;
            inc_hour_q   <= 1'b0;
            inc_min_q    <= 1'b0;
            buzzer_q     <= 1'b0;
            blink_q      <= 1'b1;
            disp_alarm_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            btn_q        <= btn_d;
            btn_prev_q   <= btn_prev_d;
            idle_q       <= idle_d;
            ring_q       <= ring_d;
            snz_q        <= snz_d;
            al_hh_q      <= al_hh_d;
            al_hl_q      <= al_hl_d;
            al_mh_q      <= al_mh_d;
            al_ml_q      <= al_ml_d;
            armed_q      <= armed_d;
            match_d_q    <= match_d_d;
            inc_hour_q   <= inc_hour_d;
            inc_min_q    <= inc_min_d;
            buzzer_q     <= buzzer_d;
            blink_q      <= blink_d;
            disp_alarm_q <= disp_alarm_d;
        end
    end

    assign inc_hour   = inc_hour_q;
    assign inc_min    = inc_min_q;
    assign al_hh      = al_hh_q;
    assign al_hl      = al_hl_q;
    assign al_mh      = al_mh_q;
    assign al_ml      = al_ml_q;
    assign disp_alarm = disp_alarm_q;
    assign blink      = blink_q;
    assign armed      = armed_q;
    assign buzzer     = buzzer_q;

endmodule

// File: tb/tb_alarm_controller.sv
// Testbench for alarm_controller: table of button/tick vectors with expected
// outputs queued on a scoreboard, plus hand-written multi-cycle sequences.
module tb_alarm_controller;

    localparam int B_MODE   = 0;
    localparam int B_HOUR   = 1;
    localparam int B_MIN    = 2;
    localparam int B_SNOOZE = 3;

    localparam logic [19:0] M_ALL   = 20'hFFFFF;
    localparam logic [19:0] M_BUZ   = 20'h00001;
    localparam logic [19:0] M_ARM   = 20'h00002;
    localparam logic [19:0] M_BLINK = 20'h00004;
    localparam logic [19:0] M_DISP  = 20'h00008;
    localparam logic [19:0] M_AL    = 20'h3FFF0;

    typedef enum int { A_PRESS, A_TICK, A_IDLE } act_e;

    typedef struct {
        act_e        act;
        int          arg;
        string       name;
        logic [19:0] exp;
        logic [19:0] mask;
    } vec_t;

    typedef struct {
        string       name;
        logic [19:0] exp;
        logic [19:0] mask;
    } sb_t;

    logic       clk_in = 1'b0;
    logic       reset = 1'b0;
    logic       tick = 1'b0;
    logic [1:0] cur_hh = 2'd1;
    logic [3:0] cur_hl = 4'd2;
    logic [3:0] cur_mh = 4'd0;
    logic [3:0] cur_ml = 4'd0;
    logic [3:0] btn_n = 4'hF;
    logic       inc_hour, inc_min, disp_alarm, blink, armed, buzzer;
    logic [1:0] al_hh;
    logic [3:0] al_hl, al_mh, al_ml;

    sb_t sb_q[$];
    int  checks = 0;
    int  failures = 0;
    vec_t tbl[17];

    always #5 clk_in = ~clk_in;

    alarm_controller #(
        .RING_SECS  (60),
        .SNOOZE_SECS(5),
        .SET_TIMEOUT(30),
        .ALARM_RST_H(7)
    ) dut (
        .clk_in    (clk_in),
        .reset     (reset),
        .tick      (tick),
        .cur_hh    (cur_hh),
        .cur_hl    (cur_hl),
        .cur_mh    (cur_mh),
        .cur_ml    (cur_ml),
        .btn_mode  (btn_n[0]),
        .btn_hour  (btn_n[1]),
        .btn_min   (btn_n[2]),
        .btn_snooze(btn_n[3]),
        .inc_hour  (inc_hour),
        .inc_min   (inc_min),
        .al_hh     (al_hh),
        .al_hl     (al_hl),
        .al_mh     (al_mh),
        .al_ml     (al_ml),
        .disp_alarm(disp_alarm),
        .blink     (blink),
        .armed     (armed),
        .buzzer    (buzzer)
    );

    // Expected output word: {inc_hour, inc_min, alarm hh:hl:mh:ml, disp, blink, armed, buzzer}.
    function automatic logic [19:0] outs(input bit ih, input bit im, input int h, input int m,
                                         input bit disp, input bit blk, input bit arm, input bit buz);
        logic [1:0] hh;
        logic [3:0] hl, mh, ml;
        hh = 2'(h / 10);
        hl = 4'(h % 10);
        mh = 4'(m / 10);
        ml = 4'(m % 10);
        return {ih, im, hh, hl, mh, ml, disp, blk, arm, buz};
    endfunction

    function automatic vec_t mkv(input act_e a, input int arg, input string n,
                                 input logic [19:0] e, input logic [19:0] m);
        vec_t v;
        v.act = a; v.arg = arg; v.name = n; v.exp = e; v.mask = m;
        return v;
    endfunction

    function automatic logic [19:0] observed();
        return {inc_hour, inc_min, al_hh, al_hl, al_mh, al_ml, disp_alarm, blink, armed, buzzer};
    endfunction

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic press_btn(input int b);
        btn_n[b] = 1'b0;
        step();
        btn_n[b] = 1'b1;
        step();
    endtask

    task automatic do_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1;
            step();
            tick = 1'b0;
        end
    endtask

    task automatic set_cur(input int h, input int m);
        cur_hh = 2'(h / 10);
        cur_hl = 4'(h % 10);
        cur_mh = 4'(m / 10);
        cur_ml = 4'(m % 10);
    endtask

    task automatic sb_push(input string n, input logic [19:0] e, input logic [19:0] m);
        sb_t s;
        s.name = n; s.exp = e; s.mask = m;
        sb_q.push_back(s);
    endtask

    task automatic sb_check();
        sb_t s;
        logic [19:0] got;
        checks++;
        if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_underflow: got empty queue, expected an entry");
        end else begin
            s = sb_q.pop_front();
            got = observed();
            if ((got & s.mask) !== (s.exp & s.mask)) begin
                failures++;
                $display("FAIL %s: got %05h expected %05h (mask %05h)", s.name,
                         got & s.mask, s.exp & s.mask, s.mask);
            end
        end
    endtask

    task automatic chk(input string n, input logic [19:0] e, input logic [19:0] m);
        sb_push(n, e, m);
        sb_check();
    endtask

    task automatic check_val(input string n, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", n, got, exp);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected bench to end");
        $fatal(1);
    end

    initial begin
        int pulses;

        // Starting state: RUN, alarm 07:00, cur 12:00.
        tbl[0]  = mkv(A_PRESS, B_MODE,   "mode_to_set_time",       outs(0,0,7,0,0,1,0,0), M_ALL);
        tbl[1]  = mkv(A_PRESS, B_MODE,   "mode_to_set_alarm",      outs(0,0,7,0,1,1,0,0), M_ALL);
        tbl[2]  = mkv(A_PRESS, B_MODE,   "mode_to_run",            outs(0,0,7,0,0,1,0,0), M_ALL);
        tbl[3]  = mkv(A_PRESS, B_SNOOZE, "arm_toggle_on",          outs(0,0,7,0,0,1,1,0), M_ALL);
        tbl[4]  = mkv(A_PRESS, B_SNOOZE, "arm_toggle_off",         outs(0,0,7,0,0,1,0,0), M_ALL);
        tbl[5]  = mkv(A_PRESS, B_HOUR,   "run_hour_ignored",       outs(0,0,7,0,0,1,0,0), M_ALL);
        tbl[6]  = mkv(A_PRESS, B_MIN,    "run_min_ignored",        outs(0,0,7,0,0,1,0,0), M_ALL);
        tbl[7]  = mkv(A_PRESS, B_MODE,   "enter_set_time",         outs(0,0,7,0,0,1,0,0), M_ALL);
        tbl[8]  = mkv(A_PRESS, B_HOUR,   "inc_hour_pulse",         outs(1,0,7,0,0,1,0,0), M_ALL);
        tbl[9]  = mkv(A_IDLE,  1,        "inc_hour_single_cycle",  outs(0,0,7,0,0,1,0,0), M_ALL);
        tbl[10] = mkv(A_PRESS, B_MIN,    "inc_min_pulse",          outs(0,1,7,0,0,1,0,0), M_ALL);
        tbl[11] = mkv(A_TICK,  1,        "set_time_blink_toggle",  outs(0,0,7,0,0,0,0,0), M_ALL);
        tbl[12] = mkv(A_PRESS, B_MODE,   "set_alarm_blink_reload", outs(0,0,7,0,1,1,0,0), M_ALL);
        tbl[13] = mkv(A_PRESS, B_HOUR,   "alarm_hour_inc",         outs(0,0,8,0,1,1,0,0), M_ALL);
        tbl[14] = mkv(A_PRESS, B_MIN,    "alarm_min_inc",          outs(0,0,8,1,1,1,0,0), M_ALL);
        tbl[15] = mkv(A_TICK,  1,        "set_alarm_blink_toggle", outs(0,0,8,1,1,0,0,0), M_ALL);
        tbl[16] = mkv(A_PRESS, B_MODE,   "alarm_to_run",           outs(0,0,8,1,0,1,0,0), M_ALL);

        // Reset held for two cycles.
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        chk("reset_values", outs(0,0,7,0,0,1,0,0), M_ALL);

        // Table-driven vectors.
        for (int i = 0; i < 17; i++) begin
            sb_push(tbl[i].name, tbl[i].exp, tbl[i].mask);
            case (tbl[i].act)
                A_PRESS: press_btn(tbl[i].arg);
                A_TICK:  do_ticks(tbl[i].arg);
                default: for (int k = 0; k < tbl[i].arg; k++) step();
            endcase
            sb_check();
        end

        // Alarm editing: from 08:01 walk to 23:59, then wrap both fields.
        press_btn(B_MODE);
        press_btn(B_MODE);
        for (int i = 0; i < 15; i++) press_btn(B_HOUR);
        chk("alarm_hour_to_23", outs(0,0,23,1,1,1,0,0), M_ALL);
        for (int i = 0; i < 8; i++) press_btn(B_MIN);
        chk("alarm_min_09", outs(0,0,23,9,1,1,0,0), M_ALL);
        press_btn(B_MIN);
        chk("alarm_min_bcd_carry", outs(0,0,23,10,1,1,0,0), M_ALL);
        for (int i = 0; i < 49; i++) press_btn(B_MIN);
        chk("alarm_23_59", outs(0,0,23,59,1,1,0,0), M_ALL);
        press_btn(B_HOUR);
        chk("alarm_hour_wrap", outs(0,0,0,59,1,1,0,0), M_ALL);
        press_btn(B_MIN);
        chk("alarm_min_wrap_no_carry", outs(0,0,0,0,1,1,0,0), M_ALL);
        for (int i = 0; i < 7; i++) press_btn(B_HOUR);
        press_btn(B_MODE);
        press_btn(B_SNOOZE);
        chk("armed_alarm_0700", outs(0,0,7,0,0,1,1,0), M_ALL);

        // Ring on match edge, beep alternation, auto-stop after 60 ticks.
        set_cur(6, 59);
        step();
        step();
        chk("no_ring_before_match", outs(0,0,7,0,0,1,1,0), M_ALL);
        set_cur(7, 0);
        step();
        chk("ring_on_match_edge", outs(0,0,7,0,0,1,1,1), M_ALL);
        do_ticks(1);
        chk("beep_phase_low", 20'h0, M_BUZ);
        do_ticks(1);
        chk("beep_phase_high", 20'h1, M_BUZ);
        do_ticks(56);
        chk("still_ringing_58", 20'h1, M_BUZ);
        do_ticks(2);
        chk("auto_stop_60", outs(0,0,7,0,0,1,1,0), M_ALL);
        do_ticks(1);
        chk("stays_quiet_after_stop", outs(0,0,7,0,0,1,1,0), M_ALL);

        // Snooze, re-ring after 5 ticks, dismiss with mode.
        set_cur(7, 1);
        step();
        set_cur(7, 0);
        step();
        chk("rering_on_new_edge", 20'h1, M_BUZ);
        press_btn(B_SNOOZE);
        chk("snooze_silences_keeps_armed", 20'h2, M_BUZ | M_ARM);
        do_ticks(4);
        chk("snooze_hold_4", 20'h0, M_BUZ);
        do_ticks(1);
        chk("snooze_rering_5", 20'h1, M_BUZ);
        press_btn(B_MODE);
        chk("dismiss_keeps_armed", outs(0,0,7,0,0,1,1,0), M_ALL);
        do_ticks(1);
        chk("dismiss_stays_silent", 20'h2, M_BUZ | M_ARM);

        // Reset while snoozing.
        set_cur(7, 1);
        step();
        set_cur(7, 0);
        step();
        press_btn(B_SNOOZE);
        do_ticks(2);
        reset = 1'b0;
        step();
        chk("reset_mid_snooze", outs(0,0,7,0,0,1,0,0), M_ALL);
        reset = 1'b1;
        step();
        do_ticks(6);
        chk("no_ring_after_reset", outs(0,0,7,0,0,1,0,0), M_ALL);

        // Set-time pulses: three presses, then one long hold.
        press_btn(B_MODE);
        chk("enter_set_time_again", 20'h4, M_DISP | M_BLINK | M_BUZ);
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            btn_n[B_HOUR] = 1'b0;
            step();
            pulses += int'(inc_hour);
            btn_n[B_HOUR] = 1'b1;
            step();
            pulses += int'(inc_hour);
            step();
            pulses += int'(inc_hour);
        end
        check_val("three_presses_three_pulses", pulses, 3);
        pulses = 0;
        btn_n[B_HOUR] = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step();
            pulses += int'(inc_hour);
        end
        btn_n[B_HOUR] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            pulses += int'(inc_hour);
        end
        check_val("held_button_one_pulse", pulses, 1);

        // Set-mode timeout at 30 idle ticks; a press restarts the count.
        do_ticks(29);
        chk("no_timeout_at_29", 20'h0, M_BLINK | M_DISP);
        do_ticks(1);
        chk("timeout_at_30", 20'h4, M_BLINK | M_DISP);
        do_ticks(1);
        chk("run_blink_forced", 20'h4, M_BLINK | M_DISP);
        press_btn(B_MODE);
        chk("mode_after_timeout_is_set_time", 20'h0, M_DISP);
        do_ticks(29);
        press_btn(B_HOUR);
        do_ticks(29);
        press_btn(B_MODE);
        chk("press_restarts_idle", 20'h8, M_DISP);
        do_ticks(29);
        chk("set_alarm_no_timeout_29", 20'h8, M_DISP | M_AL & 20'h0);
        do_ticks(1);
        chk("set_alarm_timeout_30", outs(0,0,7,0,0,1,0,0), M_ALL);

        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alarm_controller.md
# alarm_controller

Mode and alarm sequencer for the alarm clock. It sits between the debounced front-panel buttons and the BCD timekeeping chain. It sequences run, time-set and alarm-set modes, and drives single-cycle increment pulses into the minute/hour counters. It holds the alarm time, detects the alarm instant, and runs the ring/snooze cycle that drives the buzzer and the display-select lines.

## Interface
- `RING_SECS`, default 60: ticks the alarm rings before auto-stop.
- `SNOOZE_SECS`, default 300: ticks spent in snooze before re-ringing.
- `SET_TIMEOUT`, default 30: idle ticks in a set mode before returning to run.
- `ALARM_RST_H`, default 7: alarm hour (0–23) loaded at reset; alarm minute resets to 00.

Ports:
- `clk_in`, in, 1: system clock (2 kHz after PLL).
- `reset`, in, 1: synchronous, active-low reset.
- `tick`, in, 1: one-cycle 1 Hz strobe.
- `cur_hh`, in, 2: current hour tens digit (BCD).
- `cur_hl`, in, 4: current hour units digit (BCD).
- `cur_mh`, in, 4: current minute tens digit (BCD).
- `cur_ml`, in, 4: current minute units digit (BCD).
- `btn_mode`, `btn_hour`, `btn_min`, `btn_snooze`, in, 1 each: debounced buttons, active-low.
- `inc_hour`, out, 1: one-cycle pulse to the hour-units counter clock-enable.
- `inc_min`, out, 1: one-cycle pulse to the minute-units counter clock-enable.
- `al_hh`, out, 2: alarm hour tens digit (BCD).
- `al_hl`, out, 4: alarm hour units digit (BCD).
- `al_mh`, out, 4: alarm minute tens digit (BCD).
- `al_ml`, out, 4: alarm minute units digit (BCD).
- `disp_alarm`, out, 1: display mux shows alarm digits instead of current time.
- `blink`, out, 1: toggles each tick in set modes; digits blank while low.
- `armed`, out, 1: alarm enabled (drives an indicator decimal point).
- `buzzer`, out, 1: buzzer drive.

## Operation
- **Button sampling:** each button is registered every cycle. A press is a 1→0 change between consecutive samples. Releases and held levels are ignored.
- **Press priority:** if several presses occur in one cycle, `btn_mode` wins and the others are discarded.
- **States:** RUN, SET_TIME, SET_ALARM, RINGING, SNOOZE. Reset enters RUN.
- **RUN:**
  - mode press → SET_TIME.
  - snooze press toggles `armed`.
  - hour and min presses are ignored.
- **SET_TIME:**
  - mode press → SET_ALARM.
  - hour press → `inc_hour` for one cycle.
  - min press → `inc_min` for one cycle.
  - The time chain performs its own wrap; this block does not touch time digits.
- **SET_ALARM:**
  - mode press → RUN.
  - hour press → alarm hour +1, wrapping 23→00.
  - min press → alarm minute +1, wrapping 59→00 with no carry into the hour.
  - Alarm digits are stored in BCD; the units digit rolls 9→0 and carries into the tens digit.
- **Set-mode timeout:** in SET_TIME and SET_ALARM an idle counter counts ticks and clears on any press. When it reaches `SET_TIMEOUT` → RUN.
- **Match:** `match` = (cur digits == alarm digits). `match_d` registers `match` every cycle in every state.
  - Trigger = RUN ∧ `armed` ∧ `match` ∧ ¬`match_d` → RINGING.
  - Consequently, entering RUN, arming, or setting the alarm while already matching does not ring until the next match edge.
- **RINGING:**
  - Ring counter clears on entry and counts ticks.
  - `buzzer` = beep phase, toggled each tick, starting high on entry.
  - snooze press → SNOOZE.
  - mode press → RUN (dismiss; `armed` unchanged).
  - Ring count reaching `RING_SECS` → RUN.
- **SNOOZE:**
  - `buzzer` = 0.
  - Snooze counter clears on entry.
  - Counter reaching `SNOOZE_SECS` → RINGING.
  - mode press → RUN.
  - snooze press is ignored.
- **Display:**
  - `disp_alarm` = 1 only in SET_ALARM.
  - `blink` is forced 1 outside the set modes.
  - `blink` resets to 1 on entering a set mode, then toggles on each tick.
- **Reset:** synchronous, so it acts at the next clock edge even mid-ring or mid-set. Afterwards:
  - state = RUN
  - `armed` = 0
  - alarm = `ALARM_RST_H`:00
  - all counters = 0
  - `inc_hour` = `inc_min` = 0
  - `buzzer` = 0
  - `blink` = 1
  - `disp_alarm` = 0
  - `match_d` = 0
  - button sample registers = 1

## Timing
- All outputs are registered.
- A button sampled low at edge N (previous sample high) takes effect at edge N+1. This covers the state change, the alarm-register update and the start of the `inc_*` pulse.
- Each `inc_*` pulse is exactly one cycle, one pulse per press.
- A tick at edge N advances counters at edge N. State exits caused by counter terminal values happen at the same edge.
- If a press and a timeout or terminal count coincide in one cycle, the press transition wins and counters reload for the new state.
- A match edge causes RINGING one cycle after `cur_*` changes. `buzzer` rises in the same cycle.
- Counters are sized with `$clog2` of their parameter + 1. There is no overflow, because every counter is cleared on state entry.

## Test plan
- **Reset values:** hold `reset`=0 for 2 cycles, release → state RUN, alarm 07:00, `armed`=0, `buzzer`=0, `blink`=1, `disp_alarm`=0, no `inc_*` pulses.
- **Mode cycle and timeout:**
  - Mode press ×3 → SET_TIME → SET_ALARM (`disp_alarm`=1) → RUN.
  - Enter SET_TIME and apply 30 ticks without presses → RUN on the 30th tick.
  - A press at tick 29 restarts the count.
- **Alarm editing:**
  - From 23:59, hour press → 00:59; min press → 00:00 with the hour unchanged.
  - Min presses from 00:09 → 00:10 (BCD carry).
- **Set time:** in SET_TIME, 3 hour presses → exactly 3 one-cycle `inc_hour` pulses. Holding the button low for 100 cycles yields one pulse.
- **Ring and auto-stop:**
  - Armed, alarm 07:00, `cur` 06:59→07:00 → RINGING the next cycle, `buzzer` alternating per tick.
  - 60 ticks → RUN.
  - Disarming while ringing is not possible (snooze press snoozes instead).
- **Snooze and dismiss:**
  - `SNOOZE_SECS`=5: snooze press while ringing → `buzzer`=0; after 5 ticks → RINGING again.
  - Mode press → RUN with `armed`=1.
  - Reset asserted mid-SNOOZE → all reset values.
